// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared size encodings, FSM state type and alignment helper for the data-memory responder
package mips_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef logic [1:0] dmem_state_t;

   localparam dmem_state_t ST_IDLE = 2'd0;
   localparam dmem_state_t ST_BUSY = 2'd1;
   localparam dmem_state_t ST_DONE = 2'd2;

   // Half at an odd address or a word off a 4-byte boundary; size 2'b11 behaves as word.
   function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
      logic mis;
      case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = addr_lo[0];
         default: mis = (addr_lo != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - little-endian byte-lane steering for stores and load extraction/extension
module dmem_lane_align
   import mips_mem_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic [31:0] wdata,
   input  logic [31:0] raw,
   input  logic        is_signed,
   output logic [3:0]  wbe,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_ext
);

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   // Half lanes use addr[1] only, so addr[0] is dropped for halves and addr[1:0] for words.
   assign rd_byte = raw[{addr_lo, 3'b000} +: 8];
   assign rd_half = addr_lo[1] ? raw[31:16] : raw[15:0];

   // Byte enables and replicated store data; the enable picks which copy lands.
   always_comb begin
      wbe        = 4'b1111;
      wdata_lane = wdata;
      case (size)
         SZ_BYTE: begin
            wbe        = 4'b0001 << addr_lo;
            wdata_lane = {4{wdata[7:0]}};
         end
         SZ_HALF: begin
            wbe        = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_lane = {2{wdata[15:0]}};
         end
         default: begin
            wbe        = 4'b1111;
            wdata_lane = wdata;
         end
      endcase
   end

   // Load result: sign- or zero-extend sub-word reads; words pass straight through.
   always_comb begin
      rdata_ext = raw;
      case (size)
         SZ_BYTE: rdata_ext = {{24{is_signed & rd_byte[7]}}, rd_byte};
         SZ_HALF: rdata_ext = {{16{is_signed & rd_half[15]}}, rd_half};
         default: rdata_ext = raw;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle MEM-stage data memory responder; DMEM_ALIGN_CHECK_EN enables misaligned-access errors
module dmem_responder
   import mips_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
)(
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   output logic        stall,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   dmem_state_t  state;
   logic [3:0]   cnt;
   logic         lat_write;
   logic [AW+1:0] lat_addr;
   logic [31:0]  lat_wdata;
   logic [1:0]   lat_size;
   logic         lat_signed;

   logic [31:0]  mem [DEPTH_WORDS];

   logic [AW-1:0] word_idx;
   logic [31:0]  raw;
   logic [3:0]   wbe;
   logic [31:0]  wdata_lane;
   logic [31:0]  rdata_ext;
   logic         misaligned;
   logic         access_now;
   logic         unused_addr_hi;

   // Address bits above the array wrap away.
   assign unused_addr_hi = ^req_addr[31:AW+2];

   assign word_idx   = lat_addr[AW+1:2];
   assign raw        = mem[word_idx];
   assign access_now = (state == ST_BUSY) && (cnt == 4'd0);

`ifdef DMEM_ALIGN_CHECK_EN
   assign misaligned = is_misaligned(lat_addr[1:0], lat_size);
`else
   assign misaligned = 1'b0;
`endif

   dmem_lane_align u_lane_align (
      .addr_lo    (lat_addr[1:0]),
      .size       (lat_size),
      .wdata      (lat_wdata),
      .raw        (raw),
      .is_signed  (lat_signed),
      .wbe        (wbe),
      .wdata_lane (wdata_lane),
      .rdata_ext  (rdata_ext)
   );

   // Stall mirrors req_valid in IDLE so the request is frozen from its first cycle.
   always_comb begin
      stall = 1'b0;
      case (state)
         ST_IDLE: stall = req_valid;
         ST_BUSY: stall = 1'b1;
         default: stall = 1'b0;
      endcase
   end

   assign rsp_valid = (state == ST_DONE);

   // Request latch, latency counter and registered response.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         cnt        <= 4'd0;
         lat_write  <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= 32'd0;
         lat_size   <= SZ_BYTE;
         lat_signed <= 1'b0;
         rsp_rdata  <= 32'd0;
         rsp_err    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  lat_write  <= req_write;
                  lat_addr   <= req_addr[AW+1:0];
                  lat_wdata  <= req_wdata;
                  lat_size   <= req_size;
                  lat_signed <= req_signed;
                  cnt        <= 4'(LATENCY - 1);
                  state      <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (cnt == 4'd0) begin
                  rsp_rdata <= (lat_write || misaligned) ? 32'd0 : rdata_ext;
                  rsp_err   <= misaligned;
                  state     <= ST_DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: begin
               // The pipeline still shows the finished request here, so it is not re-accepted.
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Lane-masked store on the last BUSY cycle; the array itself is never reset.
   always_ff @(posedge clock) begin
      if (access_now && lat_write && !misaligned) begin
         for (int i = 0; i < 4; i++) begin
            if (wbe[i]) begin
               mem[word_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder with a byte-array reference model
module tb_dmem_responder;

   localparam int DEPTH     = 256;
   localparam int LAT       = 2;
   localparam int MEM_BYTES = 4 * DEPTH;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_signed;
   logic        stall;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int checks;
   int errors;

   logic [7:0] mmem [0:MEM_BYTES-1];

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_size   (req_size),
      .req_signed (req_signed),
      .stall      (stall),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach the end of the sequence");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_err(input logic [31:0] addr, input logic [1:0] sz);
`ifdef DMEM_ALIGN_CHECK_EN
      if (sz == 2'd1) return (addr % 2) != 0;
      if (sz >= 2'd2) return (addr % 4) != 0;
      return 1'b0;
`else
      return (addr != addr) && (sz != sz);
`endif
   endfunction

   function automatic int unsigned model_nbytes(input logic [1:0] sz);
      if (sz == 2'd0) return 1;
      if (sz == 2'd1) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] sz, input logic sg);
      int unsigned a;
      int unsigned n;
      logic [31:0] v;
      if (model_err(addr, sz)) return 32'd0;
      n = model_nbytes(sz);
      a = addr % MEM_BYTES;
      a = a - (a % n);
      v = 32'd0;
      for (int i = n - 1; i >= 0; i--) v = v * 256 + 32'(mmem[a + i]);
      if (sg && n == 1 && v >= 128)   v = v + 32'hFFFF_FF00;
      if (sg && n == 2 && v >= 32768) v = v + 32'hFFFF_0000;
      return v;
   endfunction

   task automatic model_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wd);
      int unsigned a;
      int unsigned n;
      logic [31:0] d;
      if (model_err(addr, sz)) return;
      n = model_nbytes(sz);
      a = addr % MEM_BYTES;
      a = a - (a % n);
      d = wd;
      for (int i = 0; i < n; i++) begin
         mmem[a + i] = 8'(d % 256);
         d = d / 256;
      end
   endtask

   // One request from its first cycle through DONE; hold keeps req_valid high for a back-to-back follow-on.
   task automatic do_access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [1:0] sz, input logic sg,
                            input logic [31:0] exp_rd, input logic exp_err,
                            input bit hold, input string tag);
      req_valid  = 1'b1;
      req_write  = wr;
      req_addr   = addr;
      req_wdata  = wd;
      req_size   = sz;
      req_signed = sg;
      for (int c = 0; c <= LAT + 1; c++) begin
         @(negedge clock);
         chk({tag, " stall"}, {31'd0, stall}, {31'd0, (c <= LAT)});
         chk({tag, " rsp_valid"}, {31'd0, rsp_valid}, {31'd0, (c == LAT + 1)});
         if (c == LAT + 1) begin
            chk({tag, " rdata"}, rsp_rdata, exp_rd);
            chk({tag, " err"}, {31'd0, rsp_err}, {31'd0, exp_err});
         end
         @(posedge clock);
         #1;
      end
      if (wr) model_store(addr, sz, wd);
      if (!hold) begin
         req_valid = 1'b0;
         @(negedge clock);
         chk({tag, " idle stall"}, {31'd0, stall}, 32'd0);
         chk({tag, " idle rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
         @(posedge clock);
         #1;
      end
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] wd;
      logic [1:0]  sz;
      logic        sg;
      logic        wr;
      bit          hold;

      checks = 0;
      errors = 0;
      for (int i = 0; i < MEM_BYTES; i++) mmem[i] = 8'h00;

      reset      = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      req_size   = 2'd0;
      req_signed = 1'b0;

      repeat (2) @(negedge clock);
      chk("reset stall", {31'd0, stall}, 32'd0);
      chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("reset rdata", rsp_rdata, 32'd0);
      chk("reset err", {31'd0, rsp_err}, 32'd0);
      req_valid = 1'b1;
      #1;
      chk("reset stall follows req_valid", {31'd0, stall}, 32'd1);
      req_valid = 1'b0;
      reset = 1'b1;
      @(posedge clock);
      #1;

      do_access(1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'd0, 1'b0, 1'b0, "sw 0x10");
      do_access(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, "lw 0x10");

      for (int w = 0; w < 32; w++) begin
         if (w != 4) do_access(1'b1, 32'(4 * w), 32'd0, 2'd2, 1'b0, 32'd0, 1'b0, 1'b1, "init");
      end
      req_valid = 1'b0;
      @(posedge clock);
      #1;

      do_access(1'b1, 32'h13, 32'h80, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0, "sb 0x13");
      do_access(1'b0, 32'h13, 32'd0, 2'd0, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0, "lb 0x13");
      do_access(1'b0, 32'h13, 32'd0, 2'd0, 1'b0, 32'h0000_0080, 1'b0, 1'b0, "lbu 0x13");
      do_access(1'b0, 32'h10, 32'd0, 2'd2, 1'b1, 32'h80AD_BEEF, 1'b0, 1'b0, "lw 0x10 after sb");

      do_access(1'b1, 32'h22, 32'h8001, 2'd1, 1'b0, 32'd0, 1'b0, 1'b0, "sh 0x22");
      do_access(1'b0, 32'h22, 32'd0, 2'd1, 1'b1, 32'hFFFF_8001, 1'b0, 1'b0, "lh 0x22");
      do_access(1'b0, 32'h22, 32'd0, 2'd1, 1'b0, 32'h0000_8001, 1'b0, 1'b0, "lhu 0x22");
      do_access(1'b0, 32'h20, 32'd0, 2'd1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, "lhu 0x20");
      do_access(1'b0, 32'h20, 32'd0, 2'd3, 1'b0, 32'h8001_0000, 1'b0, 1'b0, "size3 as word 0x20");

      do_access(1'b0, 32'h10 + 4 * DEPTH, 32'd0, 2'd2, 1'b0, 32'h80AD_BEEF, 1'b0, 1'b1, "b2b alias lw");
      do_access(1'b1, 32'h10 + 8 * DEPTH, 32'h1357_9BDF, 2'd2, 1'b0, 32'd0, 1'b0, 1'b1, "b2b alias sw");
      do_access(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 32'h1357_9BDF, 1'b0, 1'b0, "b2b lw 0x10");

      do_access(1'b1, 32'h40, 32'hCAFE_F00D, 2'd2, 1'b0, 32'd0, 1'b0, 1'b0, "sw 0x40");

      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_addr   = 32'h40;
      req_wdata  = 32'h1234_5678;
      req_size   = 2'd2;
      req_signed = 1'b0;
      @(negedge clock);
      chk("abort stall c0", {31'd0, stall}, 32'd1);
      @(posedge clock);
      #1;
      @(negedge clock);
      chk("abort stall c1", {31'd0, stall}, 32'd1);
      reset     = 1'b0;
      req_valid = 1'b0;
      #1;
      chk("abort stall drop", {31'd0, stall}, 32'd0);
      chk("abort rsp_valid drop", {31'd0, rsp_valid}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         chk("abort rsp_valid in reset", {31'd0, rsp_valid}, 32'd0);
      end
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         chk("abort rsp_valid after reset", {31'd0, rsp_valid}, 32'd0);
      end
      @(posedge clock);
      #1;
      do_access(1'b0, 32'h40, 32'd0, 2'd2, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, "lw 0x40 after abort");

`ifdef DMEM_ALIGN_CHECK_EN
      do_access(1'b0, 32'h41, 32'd0, 2'd2, 1'b0, 32'd0, 1'b1, 1'b0, "misaligned lw 0x41");
      do_access(1'b1, 32'h43, 32'hBEEF, 2'd1, 1'b0, 32'd0, 1'b1, 1'b0, "misaligned sh 0x43");
      do_access(1'b0, 32'h40, 32'd0, 2'd2, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, "lw 0x40 untouched");
`else
      do_access(1'b0, 32'h41, 32'd0, 2'd2, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, "misaligned lw 0x41");
      do_access(1'b1, 32'h43, 32'hBEEF, 2'd1, 1'b0, 32'd0, 1'b0, 1'b0, "misaligned sh 0x43");
      do_access(1'b0, 32'h40, 32'd0, 2'd2, 1'b0, 32'hBEEF_F00D, 1'b0, 1'b0, "lw 0x40 forced align");
`endif

      for (int n = 0; n < 80; n++) begin
         a    = 32'($urandom_range(0, 127)) + 32'(MEM_BYTES * $urandom_range(0, 3));
         wd   = $urandom;
         sz   = 2'($urandom_range(0, 3));
         sg   = 1'($urandom_range(0, 1));
         wr   = 1'($urandom_range(0, 1));
         hold = ($urandom_range(0, 1) == 1);
         do_access(wr, a, wd, sz, sg,
                   wr ? 32'd0 : model_load(a, sz, sg), model_err(a, sz), hold, "random");
      end
      req_valid = 1'b0;
      @(posedge clock);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder serving load/store requests from the pipelined MIPS CPU's MEM stage. It latches one request, holds the pipeline with `stall` for a fixed access latency, then returns read data or completes the write. It sits between the `Pipeline` MEM stage and the on-chip data array, which is internal to this block.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words; must be a power of two, ≥ 4.
- `LATENCY`, default 2: access cycles spent in BUSY; legal range 1..15.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  MEM-stage access request; held stable while `stall`=1.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `req_size`  in  2  access size: byte, half or word.
- `req_signed`  in  1  sign-extend load (LB/LH) vs zero-extend (LBU/LHU).
- `stall`  out  1  freezes the pipeline while the request is outstanding.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  32  load result, extended; 0 for stores.
- `rsp_err`  out  1  misaligned-access flag; see Configuration.

## Operation
- FSM states are IDLE, BUSY and DONE. Reset enters IDLE.
- IDLE:
  - `stall` = `req_valid`, combinational.
  - On `req_valid`, latch write, addr, wdata, size and signed; load the counter with LATENCY-1; go to BUSY.
- BUSY:
  - `stall`=1.
  - The counter decrements each cycle.
  - When the counter is 0: perform the access, register `rsp_rdata`/`rsp_err`, and go to DONE.
- DONE:
  - `stall`=0, `rsp_valid`=1; the pipeline advances at this edge.
  - `req_valid` is ignored because it still shows the old request.
  - Next state is always IDLE.
- Word index is `req_addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo the array size.
- Byte lanes are little-endian: byte lane = `addr[1:0]`, half lane = `addr[1]`.
- Stores write only the addressed lanes; other lanes keep their contents.
- Loads extend per `req_signed`. Word loads ignore `req_signed`.
- `req_size`=2'b11 is treated as word.
- The memory array is not reset. Simulation initialises it to 0.

## Timing
- The request is presented in cycle 0.
- `stall` is high in cycles 0..LATENCY, i.e. LATENCY+1 cycles.
- `rsp_valid`/`rsp_rdata` are valid in cycle LATENCY+1.
- A back-to-back request is accepted in the IDLE cycle after DONE, at the earliest LATENCY+2 cycles after the previous one.
- Reset values: `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, FSM=IDLE, counter=0. `stall` follows `req_valid` combinationally, so it is 0 if `req_valid`=0.
- Reset asserted mid-access: the access is abandoned. A store not yet written at the BUSY→DONE edge leaves memory unchanged. No `rsp_valid` is issued afterwards.
- `req_valid` dropping during BUSY is a protocol violation. The block completes from latched values regardless.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - Misaligned accesses are a half at odd address, or a word with `addr[1:0]`≠0.
  - A misaligned access performs no memory access and uses the same latency.
  - It completes with `rsp_err`=1, `rsp_rdata`=0.
- Undefined:
  - Alignment bits are forced: half ignores `addr[0]`, word ignores `addr[1:0]`.
  - `rsp_err` is tied to 0. The port exists in both builds.

## Structure
- Package `mips_mem_pkg` holds:
  - size encodings `SZ_BYTE`=2'b00, `SZ_HALF`=2'b01, `SZ_WORD`=2'b10;
  - FSM state typedef `dmem_state_t`;
  - helper function for misalignment detection.
- One sub-module, `dmem_lane_align`, is combinational:
  - from addr/size/wdata it produces the 4-bit write byte-enable and lane-shifted write data;
  - from the raw word, addr, size and signed it produces the extended load data.
- FSM, counter and array live in `dmem_responder`.

## Test plan
- Reset, then a store word: SW 0xDEADBEEF @0x10, then LW @0x10 with LATENCY=2. Expect `stall` high 3 cycles, `rsp_valid` in cycle 3, `rsp_rdata`=0xDEADBEEF.
- Byte lanes: SB 0x80 @0x13, then LB @0x13 → 0xFFFFFF80; LBU @0x13 → 0x00000080; LW @0x10 → 0x80ADBEEF.
- Halfwords: SH 0x8001 @0x22, then LH → 0xFFFF8001 and LHU → 0x00008001; the lower half @0x20 is unchanged.
- Back-to-back: the second request is held high through DONE. Expect exactly one `rsp_valid` per request and the second accepted in the IDLE cycle after DONE. Address 0x10 + 4·DEPTH_WORDS aliases to 0x10.
- Reset mid-BUSY during SW 0x12345678 @0x40: `stall` and `rsp_valid` drop immediately, and a later LW @0x40 returns the prior value.
- Misaligned LW @0x41:
  - with `DMEM_ALIGN_CHECK_EN`: `rsp_err`=1, `rsp_rdata`=0, memory untouched;
  - without it: data from word 0x40, `rsp_err`=0.
